stacker: RTL

- Packs an AXI-Stream of narrow pixel words into wide chunk phrases. Default is 8-bit pixels into 128-bit chunks, 16 pixels per chunk.
- Sits on the write side of the DRAM/FIFO path and feeds wide phrases toward memory. It is the inverse of the chunk-to-pixel unpacker on the read side.
- Packing order is little-endian: the first pixel accepted lands in chunk bits [7:0], the 16th in [127:120].
- Stream framing (tlast) is carried from pixel side to chunk side.

---
 rtl/stacker_if.sv | 11 +
 rtl/stacker.sv | 58 +++++
 2 files changed

// File: rtl/stacker_if.sv
// stacker_if: AXI-Stream channel (valid/ready/data/last) used on both sides of the stacker
interface stacker_if #(
    parameter int W = 8
);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;
    modport master(output tvalid, tdata, tlast, input tready);
    modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/stacker.sv
// stacker: packs pixels little-endian into chunk phrases; STACKER_PAD_FLUSH_EN lets tlast close a zero-padded chunk
module stacker #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CHUNK_WIDTH = 128
) (
    input logic       clk_in,
    input logic       rst_in,
    stacker_if.slave  pixel,
    stacker_if.master chunk
);
    localparam int N = CHUNK_WIDTH / PIXEL_WIDTH;
    localparam int CW = $clog2(N);
    localparam int AW = CHUNK_WIDTH - PIXEL_WIDTH;
    logic [CW-1:0]          count;
    logic [AW-1:0]          acc;
    logic [CHUNK_WIDTH-1:0] data_q, merged;
    logic                   tlast_hold, valid_q, last_q;
    logic                   full, accept_in, accept_out, complete;
    assign full = count == CW'(N - 1);
`ifdef STACKER_PAD_FLUSH_EN
    assign pixel.tready = !valid_q || chunk.tready;
    assign complete = accept_in && (full || pixel.tlast);
`else
    assign pixel.tready = !valid_q || chunk.tready || !full;
    assign complete = accept_in && full;
`endif
    assign accept_in = pixel.tvalid && pixel.tready;
    assign accept_out = valid_q && chunk.tready;
    // slots above count are always zero, so OR-ing the pixel in also zero-pads a flushed chunk
    assign merged = {{PIXEL_WIDTH{1'b0}}, acc} | (CHUNK_WIDTH'(pixel.tdata) << (PIXEL_WIDTH * count));
    assign chunk.tvalid = valid_q;
    assign chunk.tdata = data_q;
    assign chunk.tlast = last_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count      <= '0;
            acc        <= '0;
            tlast_hold <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            if (accept_out) valid_q <= 1'b0;
            if (complete) begin
                data_q     <= merged;
                last_q     <= tlast_hold | pixel.tlast;
                valid_q    <= 1'b1;
                count      <= '0;
                acc        <= '0;
                tlast_hold <= 1'b0;
            end else if (accept_in) begin
                acc        <= merged[AW-1:0];
                count      <= count + CW'(1);
                tlast_hold <= tlast_hold | pixel.tlast;
            end
        end
    end
endmodule
